// File: rtl/pong_ball_pkg.sv
// Shared constants for the Pong ball horizontal motion block.
// Optional build macro: SPEED_LEVEL3_EN. When it is defined, the hit count
// widens to 5 bits and a fourth speed level is added.
package pong_ball_pkg;

  // Motion load codes {ba,aa} presented to the ball horizontal counter
  localparam logic [1:0] MOTION_NEUTRAL = 2'b01;  // load 9, period unchanged
  localparam logic [1:0] MOTION_RIGHT   = 2'b00;  // period +1
  localparam logic [1:0] MOTION_LEFT    = 2'b10;  // period -1

  // Default speed-level thresholds (hit counts)
  localparam int MED_HITS_DEF  = 4;
  localparam int FAST_HITS_DEF = 12;
  localparam int TOP_HITS      = 20;

`ifdef SPEED_LEVEL3_EN
  localparam int HIT_CNT_W = 5;
  localparam int MAX_LEVEL = 3;
`else
  localparam int HIT_CNT_W = 4;
  localparam int MAX_LEVEL = 2;
`endif

  localparam logic [HIT_CNT_W-1:0] HIT_CNT_MAX = '1;

endpackage

// File: rtl/sync_edge_detect.sv
// Registers one level input and produces single-cycle rise/fall strobes by
// comparing the registered value with its previous registered value.
module sync_edge_detect #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic _reset,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic d_p0;
  logic d_p1;

  // Sample the input, then keep one cycle of history for edge comparison
  always_ff @(posedge clk) begin
    if (!_reset) begin
      d_p0 <= RST_VAL;
      d_p1 <= RST_VAL;
    end else begin
      d_p0 <= d;
      d_p1 <= d_p0;
    end
  end

  assign level = d_p0;
  assign rise  = d_p0 & ~d_p1;
  assign fall  = ~d_p0 & d_p1;

endmodule

// File: rtl/ball_horizontal_motion.sv
// Ball horizontal motion control for the Pong core: counts paddle hits,
// holds the ball direction and emits the per-line motion code {ba,aa}.
// Optional build macro: SPEED_LEVEL3_EN (adds speed level 3 at 20 hits).
module ball_horizontal_motion
  import pong_ball_pkg::*;
#(
  parameter int BASE_STEPS = 2,
  parameter int MED_HITS   = MED_HITS_DEF,
  parameter int FAST_HITS  = FAST_HITS_DEF
) (
  input  logic       clk7_159,
  input  logic       _reset,
  input  logic       _hit,
  input  logic       h256,
  input  logic       vblank,
  input  logic       _hblank,
  input  logic       _attract,
  input  logic       serve,
  output logic       aa,
  output logic       ba,
  output logic       move_left,
  output logic [1:0] speed_level
);

  // Wide enough to hold BASE_STEPS plus the largest speed level
  localparam int STEP_W = (BASE_STEPS + MAX_LEVEL + 1 > 3) ?
                          $clog2(BASE_STEPS + MAX_LEVEL + 1) : 2;

  logic                 hit_fall;
  logic                 vblank_lvl;
  logic                 vblank_rise;
  logic                 vblank_fall;
  logic                 hblank_fall;
  logic                 hit_level_unused;
  logic                 hit_rise_unused;
  logic                 hblank_level_unused;
  logic                 hblank_rise_unused;

  logic                 clr;
  logic [HIT_CNT_W-1:0] hit_cnt;
  logic [STEP_W-1:0]    steps_remaining;
  logic                 frame_dir;
  logic [1:0]           motion;

  // Maps the registered hit count to a speed level
  function automatic logic [1:0] level_of(input logic [HIT_CNT_W-1:0] cnt);
`ifdef SPEED_LEVEL3_EN
    if (int'(cnt) >= TOP_HITS)       return 2'd3;
`endif
    if (int'(cnt) < MED_HITS)        return 2'd0;
    else if (int'(cnt) < FAST_HITS)  return 2'd1;
    else                             return 2'd2;
  endfunction

  sync_edge_detect #(.RST_VAL(1'b1)) u_hit_edge (
    .clk   (clk7_159),
    ._reset(_reset),
    .d     (_hit),
    .level (hit_level_unused),
    .rise  (hit_rise_unused),
    .fall  (hit_fall)
  );

  sync_edge_detect #(.RST_VAL(1'b0)) u_vblank_edge (
    .clk   (clk7_159),
    ._reset(_reset),
    .d     (vblank),
    .level (vblank_lvl),
    .rise  (vblank_rise),
    .fall  (vblank_fall)
  );

  sync_edge_detect #(.RST_VAL(1'b1)) u_hblank_edge (
    .clk   (clk7_159),
    ._reset(_reset),
    .d     (_hblank),
    .level (hblank_level_unused),
    .rise  (hblank_rise_unused),
    .fall  (hblank_fall)
  );

  // Attract mode or a serve in progress clears the rally
  assign clr = !_attract | serve;

  // Hit counter (saturating, cleared by clr) and direction taken from h256
  always_ff @(posedge clk7_159) begin
    if (!_reset) begin
      hit_cnt   <= '0;
      move_left <= 1'b0;
    end else begin
      if (hit_fall) move_left <= h256;
      if (clr)
        hit_cnt <= '0;
      else if (hit_fall && hit_cnt != HIT_CNT_MAX)
        hit_cnt <= hit_cnt + 1'b1;
    end
  end

  assign speed_level = level_of(hit_cnt);

  // Frame latch at vblank start and one motion step per line while steps remain
  always_ff @(posedge clk7_159) begin
    if (!_reset) begin
      steps_remaining <= '0;
      frame_dir       <= 1'b0;
      motion          <= MOTION_NEUTRAL;
    end else begin
      if (clr)
        motion <= MOTION_NEUTRAL;
      else if (hblank_fall) begin
        if (vblank_lvl && steps_remaining != '0)
          motion <= frame_dir ? MOTION_LEFT : MOTION_RIGHT;
        else
          motion <= MOTION_NEUTRAL;
      end

      if (vblank_rise) begin
        steps_remaining <= STEP_W'(BASE_STEPS) + STEP_W'(speed_level);
        frame_dir       <= move_left;
      end else if (vblank_fall)
        steps_remaining <= '0;
      else if (hblank_fall && vblank_lvl && steps_remaining != '0 && !clr)
        steps_remaining <= steps_remaining - 1'b1;
    end
  end

  assign {ba, aa} = motion;

endmodule

// File: tb/tb_ball_horizontal_motion.sv
// Directed bench for ball_horizontal_motion. Stimulus pushes the expected
// per-line result into a queue; a monitor pops it on every line.
module tb_ball_horizontal_motion;

  localparam logic [1:0] NEU = 2'b01;
  localparam logic [1:0] RGT = 2'b00;
  localparam logic [1:0] LFT = 2'b10;

`ifdef SPEED_LEVEL3_EN
  localparam logic [1:0] SL_SAT = 2'd3;  // 22 hits
  localparam int         ST_SAT = 5;
`else
  localparam logic [1:0] SL_SAT = 2'd2;  // 22 hits saturate at 15
  localparam int         ST_SAT = 4;
`endif

  logic       clk7_159 = 1'b0;
  logic       _reset;
  logic       _hit;
  logic       h256;
  logic       vblank;
  logic       _hblank;
  logic       _attract;
  logic       serve;
  logic       aa;
  logic       ba;
  logic       move_left;
  logic [1:0] speed_level;

  typedef struct {
    logic [1:0] code;
    logic       ml;
    logic [1:0] sl;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   line_no = 0;

  always #70 clk7_159 = ~clk7_159;

  ball_horizontal_motion dut (
    .clk7_159   (clk7_159),
    ._reset     (_reset),
    ._hit       (_hit),
    .h256       (h256),
    .vblank     (vblank),
    ._hblank    (_hblank),
    ._attract   (_attract),
    .serve      (serve),
    .aa         (aa),
    .ba         (ba),
    .move_left  (move_left),
    .speed_level(speed_level)
  );

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s (line %0d): got %0d, expected %0d", name, line_no, act, req);
    end
  endtask

  // Monitor: the code is valid a few cycles after each _hblank fall
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge _hblank);
      repeat (3) @(posedge clk7_159);
      @(negedge clk7_159);
      line_no++;
      if (exp_q.size() == 0) begin
        check("expectation_present", 0, 1);
      end else begin
        e = exp_q.pop_front();
        check("line_code", int'({ba, aa}), int'(e.code));
        check("line_move_left", int'(move_left), int'(e.ml));
        check("line_speed_level", int'(speed_level), int'(e.sl));
      end
    end
  end

  initial begin : watchdog
    #(140 * 30000);
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk7_159);
  endtask

  task automatic line(input logic [1:0] code, input logic ml, input logic [1:0] sl);
    exp_t e;
    _hblank = 1'b1;
    cyc(4);
    e.code = code;
    e.ml   = ml;
    e.sl   = sl;
    exp_q.push_back(e);
    _hblank = 1'b0;
    cyc(6);
  endtask

  task automatic vb_start();
    vblank = 1'b1;
    cyc(4);
  endtask

  task automatic vb_end();
    vblank = 1'b0;
    cyc(4);
  endtask

  task automatic hits(input int n, input logic h);
    for (int i = 0; i < n; i++) begin
      h256 = h;
      _hit = 1'b0;
      cyc(3);
      _hit = 1'b1;
      cyc(3);
    end
  endtask

  // Six lines inside vblank: the first 'steps' carry 'code', the rest neutral
  task automatic vb_lines(input int steps, input logic [1:0] code,
                          input logic ml, input logic [1:0] sl);
    for (int i = 0; i < 6; i++)
      line((i < steps) ? code : NEU, ml, sl);
  endtask

  task automatic active_lines(input logic ml, input logic [1:0] sl);
    line(NEU, ml, sl);
    line(NEU, ml, sl);
  endtask

  task automatic frame(input int steps, input logic [1:0] code,
                       input logic ml, input logic [1:0] sl);
    vb_start();
    vb_lines(steps, code, ml, sl);
    vb_end();
    active_lines(ml, sl);
  endtask

  initial begin : stimulus
    _reset   = 1'b0;
    _hit     = 1'b1;
    h256     = 1'b0;
    vblank   = 1'b0;
    _hblank  = 1'b1;
    _attract = 1'b1;
    serve    = 1'b0;
    cyc(3);
    check("reset_code", int'({ba, aa}), int'(NEU));
    check("reset_move_left", int'(move_left), 0);
    check("reset_speed_level", int'(speed_level), 0);
    _reset = 1'b1;
    cyc(4);

    // Three idle frames: two right steps each
    frame(2, RGT, 1'b0, 2'd0);
    frame(2, RGT, 1'b0, 2'd0);
    frame(2, RGT, 1'b0, 2'd0);

    // Four hits from the right half inside vblank: this frame keeps old steps/direction
    vb_start();
    hits(4, 1'b1);
    vb_lines(2, RGT, 1'b1, 2'd1);
    vb_end();
    active_lines(1'b1, 2'd1);
    frame(3, LFT, 1'b1, 2'd1);

    // Eight more hits (12 total): level 2 shows up in the following frame
    vb_start();
    hits(8, 1'b1);
    vb_lines(3, LFT, 1'b1, 2'd2);
    vb_end();
    active_lines(1'b1, 2'd2);
    frame(4, LFT, 1'b1, 2'd2);

    // Ten more hits (22 total): count saturates
    vb_start();
    hits(10, 1'b1);
    vb_lines(4, LFT, 1'b1, SL_SAT);
    vb_end();
    active_lines(1'b1, SL_SAT);
    frame(ST_SAT, LFT, 1'b1, SL_SAT);

    // Serve starts mid-vblank together with a left-half hit
    vb_start();
    line(LFT, 1'b1, SL_SAT);
    line(LFT, 1'b1, SL_SAT);
    serve = 1'b1;
    h256  = 1'b0;
    _hit  = 1'b0;
    cyc(3);
    _hit  = 1'b1;
    cyc(3);
    for (int i = 0; i < 4; i++) line(NEU, 1'b0, 2'd0);
    vb_end();
    serve = 1'b0;
    active_lines(1'b0, 2'd0);
    frame(2, RGT, 1'b0, 2'd0);

    // Attract mode for a whole frame, hits ignored by the counter
    _attract = 1'b0;
    vb_start();
    hits(4, 1'b0);
    vb_lines(0, NEU, 1'b0, 2'd0);
    vb_end();
    active_lines(1'b0, 2'd0);
    _attract = 1'b1;
    frame(2, RGT, 1'b0, 2'd0);

    // Build left motion, then reset in the middle of a motion line
    vb_start();
    hits(4, 1'b1);
    vb_lines(2, RGT, 1'b1, 2'd1);
    vb_end();
    active_lines(1'b1, 2'd1);
    vb_start();
    line(LFT, 1'b1, 2'd1);
    line(LFT, 1'b1, 2'd1);
    _reset = 1'b0;
    cyc(1);
    _reset  = 1'b1;
    vblank  = 1'b0;
    _hblank = 1'b1;
    check("midreset_code", int'({ba, aa}), int'(NEU));
    check("midreset_move_left", int'(move_left), 0);
    check("midreset_speed_level", int'(speed_level), 0);
    cyc(4);
    active_lines(1'b0, 2'd0);
    frame(2, RGT, 1'b0, 2'd0);

    cyc(4);
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ball_horizontal_motion.md
Name: ball_horizontal_motion

Overview:
- Upstream stage of the ball horizontal video counter in the Pong core.
- Counts paddle hits and holds the ball's horizontal direction.
- Emits the per-line motion load code {ba,aa} that lengthens or shortens the ball counter period on a limited number of lines per frame.
- All logic runs on the 7.159 MHz pixel clock; strobes are derived internally from level inputs.

Parameters:
- BASE_STEPS, 2, motion lines applied per frame at speed level 0; level N applies BASE_STEPS+N lines.
- MED_HITS, 4, hit count at which speed level becomes 1.
- FAST_HITS, 12, hit count at which speed level becomes 2.

Ports:
- clk7_159  in  1  pixel clock; the only clock.
- _reset  in  1  synchronous active-low reset.
- _hit  in  1  active-low paddle-hit level; its falling edge is one hit.
- h256  in  1  ball horizontal half at hit time; 1 = right half.
- vblank  in  1  vertical blank, active high.
- _hblank  in  1  horizontal blank, active low.
- _attract  in  1  attract mode, active low.
- serve  in  1  serve in progress, active high.
- aa  out  1  motion code bit 0 to the ball video counter.
- ba  out  1  motion code bit 1.
- move_left  out  1  current direction; 1 = moving left.
- speed_level  out  2  current speed level, 0..2 (0..3 with option).

Behaviour:
- Clock and reset: one clock, clk7_159; reset `_reset` is synchronous and active-low, as already decided.
- Reset values:
  - {ba,aa}=2'b01 (neutral).
  - move_left=0.
  - speed_level=0.
  - hit count=0.
  - steps_remaining=0.
  - Edge registers hold the inactive input levels: _hit=1, vblank=0, _hblank=1.
- Edge detection:
  - Each input is registered once; an edge is the current registered value differing from the previous one.
  - Each edge produces exactly one single-cycle strobe.
- Motion codes:
  - 2'b01 = neutral (load 9).
  - 2'b00 = right step (period +1).
  - 2'b10 = left step (period -1).
  - 2'b11 is never driven.
- Clear condition: clr = !_attract | serve, evaluated every cycle.
  - While clr is active: hit count is held at 0 and {ba,aa} is forced to neutral.
  - Direction is retained.
- Hit strobe (falling edge of _hit):
  - Hit count increments, saturating at 15.
  - move_left <= h256.
  - If the hit strobe and clr coincide, clr wins for the count; direction is still updated.
- speed_level:
  - 0 when count < MED_HITS.
  - 1 when count < FAST_HITS.
  - 2 otherwise.
  - Updates combinationally from the registered count, with no extra latency.
- Frame latch (vblank rising strobe):
  - steps_remaining <= BASE_STEPS + speed_level.
  - frame_dir <= move_left.
  - Hits later in the frame affect only the next frame.
- Line update (_hblank falling strobe):
  - If vblank is 1, steps_remaining > 0 and clr is inactive: {ba,aa} <= frame_dir ? 2'b10 : 2'b00, and steps_remaining decrements.
  - Otherwise {ba,aa} <= neutral.
  - The code changes on the cycle after the strobe and holds for the whole line.
- vblank falling: steps_remaining <= 0; the code returns to neutral at the next _hblank falling.
- Reset asserted mid-frame: all state returns to reset values on that edge; no partial step completes.

Optional Feature:
- Macro: SPEED_LEVEL3_EN.
- With the macro defined:
  - Hit count is 5-bit and saturates at 31.
  - speed_level=3 at count >= 20.
  - Frame steps become BASE_STEPS+3.
- Without the macro: 4-bit count saturating at 15; speed_level maximum is 2.

Decomposition:
- Package pong_ball_pkg holds:
  - motion code constants: MOTION_NEUTRAL, MOTION_RIGHT, MOTION_LEFT;
  - speed-level thresholds;
  - hit count width, selected by the macro.
- One sub-module: sync_edge_detect.
  - Single-bit register with rise and fall strobe outputs.
  - Same clock and synchronous active-low reset.
  - Instantiated three times: _hit, vblank, _hblank.

Test Plan:
- Release reset, _attract=1, serve=0, 3 frames with no hits -> each frame exactly 2 lines of {ba,aa}=00, all other lines 01; move_left=0; speed_level=0.
- Hit pulses with h256=1, then count to 4 hits -> move_left=1 and speed_level=1; the next frame has 3 lines of 10; the frame in which the hit occurred keeps its old direction and step count.
- 12 hits, then 10 more -> speed_level=2 and count saturates at 15; with SPEED_LEVEL3_EN, 20 hits -> speed_level=3 and 5 lines of 10 per frame.
- serve=1 mid-vblank, with a hit on the same cycle -> code 01 on the next line; count=0; direction follows h256 of the hit.
- _attract=0 for a full frame -> no motion lines; count held at 0; after release, 2 motion lines on the next vblank.
- _reset=0 for one cycle during a motion line -> next cycle {ba,aa}=01, move_left=0, speed_level=0, no remaining steps that frame.
